ccx_emem_responder: RTL
=======================

CCX_EMEM_RESPONDER -- requirements
Module: ccx_emem_responder

Interface
REQ-001 SHALL have parameter BASE, default 39'h0010_0000, meaning the first byte address served.
REQ-002 SHALL have parameter DEPTH, default 512, meaning the number of 64-bit words in the backing store (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, meaning the cycles from request capture to gnt (legal range 1..15).
REQ-004 SHALL have parameter READ_ONLY, default 1'b0, meaning writes are refused with an error when set.
REQ-005 SHALL have parameter EXEC_EN, default 1'b1, meaning instruction fetches are permitted when set.
REQ-006 SHALL have port f_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port g_resetn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port emem_req, input, 1 bit: request valid.
REQ-009 SHALL have port emem_rtype, input, 1 bit: request type (1 = instruction fetch, 0 = data).
REQ-010 SHALL have port emem_addr, input, 39 bits: byte address; bits [2:0] ignored.
REQ-011 SHALL have port emem_wen, input, 1 bit: write enable.
REQ-012 SHALL have port emem_strb, input, 8 bits: byte write strobe.
REQ-013 SHALL have port emem_wdata, input, 64 bits: write data.
REQ-014 SHALL have port emem_gnt, output, 1 bit: response valid.
REQ-015 SHALL have port emem_err, output, 1 bit: response error.
REQ-016 SHALL have port emem_rdata, output, 64 bits: response read data.

Function
REQ-017 SHALL implement states IDLE, WAIT and RESP; all outputs SHALL be registered.
REQ-018 In IDLE with emem_req=1, SHALL capture rtype, addr, wen, strb and wdata, load the wait counter with LATENCY-1, and enter WAIT (or RESP directly when LATENCY=1).
REQ-019 In WAIT, SHALL decrement the counter each cycle and enter RESP when the counter reaches 0.
REQ-020 SHALL assert emem_gnt for exactly one cycle in RESP, LATENCY cycles after the capture edge, then return to IDLE.
REQ-021 Back-to-back: a request still high in the cycle after RESP SHALL be captured as a new transaction; minimum request spacing is LATENCY+1 cycles.
REQ-022 SHALL process only captured values; emem_req deasserting or inputs changing before gnt SHALL NOT abort or alter the transaction.
REQ-023 Error conditions (any one raises err): word index (addr-BASE)>>3 outside 0..DEPTH-1 (unsigned 39-bit subtraction, so addr<BASE wraps and errors); wen=1 with READ_ONLY=1; rtype=1 with EXEC_EN=0.
REQ-024 Non-error read: emem_rdata = mem[index] and emem_err=0 during gnt.
REQ-025 Non-error write: bytes whose strb bit is set SHALL be updated on the RESP edge; emem_rdata=0 during gnt; strb=8'h00 is a legal no-op write.
REQ-026 Error response: no memory update, emem_rdata=0 and emem_err=1 during gnt.
REQ-027 When emem_gnt=0, emem_err SHALL be 0 and emem_rdata SHALL be 0.
REQ-028 A read following a write to the same word SHALL return the written data.

Reset
REQ-029 When g_resetn=0, SHALL immediately force state=IDLE, counter=0, emem_gnt=0, emem_err=0 and emem_rdata=64'h0, independent of f_clk.
REQ-030 Reset mid-transaction SHALL discard it with no gnt and no memory write; memory contents SHALL NOT be reset.
REQ-031 The first capture after reset release SHALL occur on the first rising edge with g_resetn=1 and emem_req=1.

Verification
REQ-032 LATENCY=2: write addr=BASE+8, strb=8'hFF, wdata=64'h0123_4567_89AB_CDEF, then read BASE+8 -> each gnt 2 cycles after capture; read returns 64'h0123_4567_89AB_CDEF, err=0.
REQ-033 Partial write: strb=8'h0F, wdata=64'hFFFF_FFFF_FFFF_FFFF over the word above, then read -> 64'h0123_4567_FFFF_FFFF.
REQ-034 Read addr=BASE+DEPTH*8 and read addr=BASE-8 -> each gnt with err=1, rdata=0.
REQ-035 READ_ONLY=1 write to BASE; EXEC_EN=0 fetch (rtype=1) from BASE -> err=1; subsequent data read of BASE returns the unchanged value.
REQ-036 emem_req held high continuously for 3 reads -> gnt pulses spaced exactly LATENCY+1 cycles apart, each one cycle wide.
REQ-037 g_resetn pulsed low during WAIT of a write -> no gnt, outputs 0 asynchronously; a later read of that word returns the pre-write value.

Source files
------------

// File: rtl/ccx_emem_responder.sv
// Fixed-latency 64-bit word memory responder for the CCX external memory port.
// One transaction in flight: capture, count down LATENCY cycles, then a single registered gnt.
module ccx_emem_responder #(
  parameter logic [38:0] BASE      = 39'h0010_0000,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned LATENCY   = 2,
  parameter bit          READ_ONLY = 1'b0,
  parameter bit          EXEC_EN   = 1'b1
) (
  input  logic        f_clk,
  input  logic        g_resetn,
  input  logic        emem_req,
  input  logic        emem_rtype,
  input  logic [38:0] emem_addr,
  input  logic        emem_wen,
  input  logic [7:0]  emem_strb,
  input  logic [63:0] emem_wdata,
  output logic        emem_gnt,
  output logic        emem_err,
  output logic [63:0] emem_rdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_capture;

  logic        r_rtype;
  logic [38:0] r_addr;
  logic        r_wen;
  logic [7:0]  r_strb;
  logic [63:0] r_wdata;

  logic [38:0] w_off;
  logic [38:0] w_word;
  logic [AW-1:0] w_idx;
  logic        w_err;
  logic        w_mem_we;
  logic        w_gnt_nxt;
  logic        w_err_nxt;
  logic [63:0] w_rdata_nxt;

  logic [63:0] r_mem [DEPTH];

  // Unsigned wrap makes addresses below BASE land far out of range.
  assign w_off    = r_addr - BASE;
  assign w_word   = w_off >> 3;
  assign w_idx    = w_word[AW-1:0];
  assign w_err    = (w_word >= 39'(DEPTH)) | (r_wen & READ_ONLY) | (r_rtype & ~EXEC_EN);
  assign w_mem_we = (r_state == S_RESP) & r_wen & ~w_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (emem_req) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = 4'(LATENCY - 1);
          w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The response is registered on the RESP edge, so gnt lands LATENCY edges after capture.
  always_comb begin
    w_gnt_nxt   = (r_state == S_RESP);
    w_err_nxt   = (r_state == S_RESP) & w_err;
    w_rdata_nxt = '0;
    if ((r_state == S_RESP) && !w_err && !r_wen) begin
      w_rdata_nxt = r_mem[w_idx];
    end
  end

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      emem_gnt   <= 1'b0;
      emem_err   <= 1'b0;
      emem_rdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      emem_gnt   <= w_gnt_nxt;
      emem_err   <= w_err_nxt;
      emem_rdata <= w_rdata_nxt;
    end
  end

  always_ff @(posedge f_clk) begin
    if (w_capture) begin
      r_rtype <= emem_rtype;
      r_addr  <= emem_addr;
      r_wen   <= emem_wen;
      r_strb  <= emem_strb;
      r_wdata <= emem_wdata;
    end
  end

  always_ff @(posedge f_clk) begin
    if (w_mem_we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (r_strb[b]) begin
          r_mem[w_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule
